// File: rtl/motor_bus_pkg.sv
// Shared types for the motor bus scheduler and the frame engine.
// Frame-type codes are the on-wire command encoding.
package motor_bus_pkg;

   localparam logic [1:0] FRAME_STATUS_REQUEST = 2'd0;
   localparam logic [1:0] FRAME_SETPOINT       = 2'd1;
   localparam logic [1:0] FRAME_CONTROL_MODE   = 2'd2;

   typedef enum logic [1:0] {
      CMD_STATUS_REQUEST = FRAME_STATUS_REQUEST,
      CMD_SETPOINT       = FRAME_SETPOINT,
      CMD_CONTROL_MODE   = FRAME_CONTROL_MODE
   } cmd_type_e;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_STATUS,
      WAIT_TX_STATUS,
      WAIT_RESP,
      ISSUE_UPDATE,
      WAIT_TX_UPDATE
   } state_e;

   // A zero poll rate is treated as 1 Hz.
   function automatic logic [31:0] slot_period(
      input int unsigned clk_hz,
      input logic [31:0] freq_hz,
      input int unsigned motors
   );
      logic [31:0] f;
      f = (freq_hz == 32'd0) ? 32'd1 : freq_hz;
      return (32'(clk_hz) / f) / 32'(motors);
   endfunction

endpackage

// File: rtl/motor_bus_slot_timer.sv
// Slot down-counter: reloads on start, holds at zero once expired.
module motor_bus_slot_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] period,
   input  logic        start,
   output logic        expired
);

   logic [31:0] cnt_q, cnt_d;

   // Loading period-1 makes consecutive starts exactly 'period' apart.
   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = (period == 32'd0) ? 32'd0 : period - 32'd1;
      end else if (cnt_q != 32'd0) begin
         cnt_d = cnt_q - 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == 32'd0);

endmodule

// File: rtl/motor_bus_scheduler.sv
// Round-robin motor bus poller: status request per slot, then an
// optional control-mode or setpoint frame, with link tracking.
module motor_bus_scheduler
   import motor_bus_pkg::*;
#(
   parameter int NUMBER_OF_MOTORS        = 8,
   parameter int CLK_FREQ_HZ             = 50_000_000,
   parameter int RESPONSE_TIMEOUT_CYCLES = 4000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [31:0]                 update_frequency_Hz,
   input  logic [NUMBER_OF_MOTORS-1:0] enable_mask,
   input  logic [NUMBER_OF_MOTORS-1:0] cm_update_req,
   input  logic [NUMBER_OF_MOTORS-1:0] sp_update_req,
   output logic                        cmd_valid,
   input  logic                        cmd_ready,
   output logic [1:0]                  cmd_type,
   output logic [7:0]                  cmd_motor,
   input  logic                        cmd_done,
   input  logic                        rsp_ok,
   input  logic                        rsp_err,
   output logic [NUMBER_OF_MOTORS-1:0] link_up,
   output logic [15:0]                 overrun_count
);

   localparam int N  = NUMBER_OF_MOTORS;
   localparam int MW = (N > 1) ? $clog2(N) : 1;

   state_e                state_q, state_d;
   cmd_type_e             type_q, type_d;
   logic                  valid_q, valid_d;
   logic [7:0]            motor_q, motor_d;
   logic [N-1:0]          link_q, link_d;
   logic [N-1:0]          pcm_q, pcm_d;
   logic [N-1:0]          psp_q, psp_d;
   logic [N-1:0]          clr_cm, clr_sp;
   logic [N-1:0][1:0]     fail_q, fail_d;
   logic [31:0]           rsp_cnt_q, rsp_cnt_d;
   logic [15:0]           ovr_q, ovr_d;
   logic                  ovr_seen_q, ovr_seen_d;
   logic                  slot_start;
   logic                  expired;
   logic [31:0]           period;
   logic [MW-1:0]         cur;
   logic [7:0]            next_motor;
   logic [1:0]            fail_inc;

   assign cur    = motor_q[MW-1:0];
   assign period = slot_period(CLK_FREQ_HZ, update_frequency_Hz, N);

   motor_bus_slot_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .period  (period),
      .start   (slot_start),
      .expired (expired)
   );

   // Lowest enabled index above cur wins; otherwise wrap to lowest.
   always_comb begin
      next_motor = motor_q;
      for (int j = N - 1; j >= 0; j--) begin
         if (enable_mask[j]) next_motor = 8'(j);
      end
      for (int j = N - 1; j >= 0; j--) begin
         if (enable_mask[j] && (j > int'(cur))) next_motor = 8'(j);
      end
   end

   always_comb begin
      state_d    = state_q;
      type_d     = type_q;
      motor_d    = motor_q;
      link_d     = link_q;
      fail_d     = fail_q;
      clr_cm     = '0;
      clr_sp     = '0;
      slot_start = 1'b0;
      rsp_cnt_d  = rsp_cnt_q;
      fail_inc   = (fail_q[cur] == 2'd3) ? 2'd3 : fail_q[cur] + 2'd1;
      if ((state_q == WAIT_RESP) && (rsp_cnt_q != 32'd0)) begin
         rsp_cnt_d = rsp_cnt_q - 32'd1;
      end
      unique case (state_q)
         IDLE: begin
            if (expired && (|enable_mask)) begin
               slot_start = 1'b1;
               motor_d    = next_motor;
               type_d     = CMD_STATUS_REQUEST;
               state_d    = ISSUE_STATUS;
            end
         end
         ISSUE_STATUS: begin
            if (valid_q && cmd_ready) state_d = WAIT_TX_STATUS;
         end
         WAIT_TX_STATUS: begin
            if (cmd_done) begin
               rsp_cnt_d = 32'(RESPONSE_TIMEOUT_CYCLES);
               state_d   = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            if (rsp_ok) begin
               link_d[cur] = 1'b1;
               fail_d[cur] = 2'd0;
               if (pcm_q[cur] || !link_q[cur]) begin
                  type_d  = CMD_CONTROL_MODE;
                  state_d = ISSUE_UPDATE;
               end else if (psp_q[cur]) begin
                  type_d  = CMD_SETPOINT;
                  state_d = ISSUE_UPDATE;
               end else begin
                  state_d = IDLE;
               end
            end else if (rsp_err || (rsp_cnt_q == 32'd0)) begin
               fail_d[cur] = fail_inc;
               if (fail_inc == 2'd3) link_d[cur] = 1'b0;
               state_d = IDLE;
            end
         end
         ISSUE_UPDATE: begin
            if (valid_q && cmd_ready) begin
               // A control-mode frame also carries the setpoint.
               clr_sp[cur] = 1'b1;
               clr_cm[cur] = (type_q == CMD_CONTROL_MODE);
               state_d     = WAIT_TX_UPDATE;
            end
         end
         WAIT_TX_UPDATE: begin
            if (cmd_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      valid_d = (state_d == ISSUE_STATUS) || (state_d == ISSUE_UPDATE);
      pcm_d   = (pcm_q & ~clr_cm) | cm_update_req;
      psp_d   = (psp_q & ~clr_sp) | sp_update_req;
   end

   // One overrun per slot; the flag re-arms at the next slot start.
   always_comb begin
      ovr_d      = ovr_q;
      ovr_seen_d = ovr_seen_q;
      if (slot_start) begin
         ovr_seen_d = 1'b0;
      end else if (expired && (state_q != IDLE) && !ovr_seen_q) begin
         ovr_seen_d = 1'b1;
         if (ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         type_q     <= CMD_STATUS_REQUEST;
         valid_q    <= 1'b0;
         motor_q    <= 8'(N - 1);
         link_q     <= '0;
         pcm_q      <= '0;
         psp_q      <= '0;
         fail_q     <= '0;
         rsp_cnt_q  <= '0;
         ovr_q      <= '0;
         ovr_seen_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         type_q     <= type_d;
         valid_q    <= valid_d;
         motor_q    <= motor_d;
         link_q     <= link_d;
         pcm_q      <= pcm_d;
         psp_q      <= psp_d;
         fail_q     <= fail_d;
         rsp_cnt_q  <= rsp_cnt_d;
         ovr_q      <= ovr_d;
         ovr_seen_q <= ovr_seen_d;
      end
   end

   assign cmd_valid     = valid_q;
   assign cmd_type      = type_q;
   assign cmd_motor     = motor_q;
   assign link_up       = link_q;
   assign overrun_count = ovr_q;

endmodule

// File: tb/tb_motor_bus_scheduler.sv
// Scoreboard bench for motor_bus_scheduler: stimulus queues the
// expected commands, a monitor checks each accepted command.
module tb_motor_bus_scheduler;

   localparam logic [1:0] ST = 2'd0;
   localparam logic [1:0] SP = 2'd1;
   localparam logic [1:0] CM = 2'd2;
   localparam int R_OK   = 0;
   localparam int R_ERR  = 1;
   localparam int R_NONE = 2;

   typedef struct packed {
      logic [1:0] t;
      logic [7:0] m;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] update_frequency_Hz;
   logic [3:0]  enable_mask;
   logic [3:0]  cm_update_req;
   logic [3:0]  sp_update_req;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_type;
   logic [7:0]  cmd_motor;
   logic        cmd_done;
   logic        rsp_ok;
   logic        rsp_err;
   logic [3:0]  link_up;
   logic [15:0] overrun_count;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   motor_bus_scheduler #(
      .NUMBER_OF_MOTORS        (4),
      .CLK_FREQ_HZ             (50_000_000),
      .RESPONSE_TIMEOUT_CYCLES (4000)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .update_frequency_Hz (update_frequency_Hz),
      .enable_mask         (enable_mask),
      .cm_update_req       (cm_update_req),
      .sp_update_req       (sp_update_req),
      .cmd_valid           (cmd_valid),
      .cmd_ready           (cmd_ready),
      .cmd_type            (cmd_type),
      .cmd_motor           (cmd_motor),
      .cmd_done            (cmd_done),
      .rsp_ok              (rsp_ok),
      .rsp_err             (rsp_err),
      .link_up             (link_up),
      .overrun_count       (overrun_count)
   );

   // Inputs only change #1 after posedge, so negedge sees a stable handshake.
   always @(negedge clk) begin
      if (!reset && cmd_valid && cmd_ready) begin
         exp_t e;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL cmd_unexpected: got type %0d motor %0d, required none",
                     cmd_type, cmd_motor);
         end else begin
            e = exp_q.pop_front();
            if (cmd_type !== e.t || cmd_motor !== e.m) begin
               miscompares++;
               $display("FAIL cmd: got type %0d motor %0d, required type %0d motor %0d",
                        cmd_type, cmd_motor, e.t, e.m);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic serve(input logic [1:0] et, input int em, input int rdy_dly,
                        input int rsp, input int rsp_dly, input logic [3:0] cm_acc);
      int n;
      exp_q.push_back(exp_t'{t: et, m: 8'(em)});
      n = 0;
      while (!cmd_valid && n < 10000) begin
         tick();
         n++;
      end
      if (!cmd_valid) begin
         vectors++;
         miscompares++;
         $display("FAIL cmd_wait: got no cmd_valid in 10000 cycles, required type %0d motor %0d",
                  et, em);
         return;
      end
      for (int i = 0; i < rdy_dly; i++) begin
         vectors++;
         if (cmd_valid !== 1'b1 || cmd_type !== et || cmd_motor !== 8'(em)) begin
            miscompares++;
            $display("FAIL hold_stable: got v%0d type %0d motor %0d, required v1 type %0d motor %0d",
                     cmd_valid, cmd_type, cmd_motor, et, em);
         end
         tick();
      end
      cmd_ready     = 1'b1;
      cm_update_req = cm_acc;
      tick();
      cmd_ready     = 1'b0;
      cm_update_req = '0;
      tick();
      tick();
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      if (et == ST) begin
         repeat (rsp_dly) tick();
         if (rsp == R_OK) rsp_ok = 1'b1;
         if (rsp == R_ERR) rsp_err = 1'b1;
         if (rsp != R_NONE) begin
            tick();
            rsp_ok  = 1'b0;
            rsp_err = 1'b0;
         end
      end
   endtask

   initial begin
      int n;
      reset               = 1'b1;
      update_frequency_Hz = 32'd10000;
      enable_mask         = 4'b1011;
      cm_update_req       = '0;
      sp_update_req       = '0;
      cmd_ready           = 1'b0;
      cmd_done            = 1'b0;
      rsp_ok              = 1'b0;
      rsp_err             = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 32'(cmd_valid), 32'd0);
      chk("rst_type", 32'(cmd_type), 32'd0);
      chk("rst_motor", 32'(cmd_motor), 32'd3);
      chk("rst_link", 32'(link_up), 32'd0);
      chk("rst_overrun", 32'(overrun_count), 32'd0);
      reset = 1'b0;

      // Round robin over 1011, link-down motors get a control-mode frame.
      serve(ST, 0, 0, R_OK, 2, '0);
      serve(CM, 0, 0, R_NONE, 0, '0);
      serve(ST, 1, 0, R_OK, 2, '0);
      serve(CM, 1, 0, R_NONE, 0, '0);
      serve(ST, 3, 0, R_OK, 2, '0);
      serve(CM, 3, 0, R_NONE, 0, '0);
      serve(ST, 0, 0, R_OK, 2, '0);
      chk("link_after_round", 32'(link_up), 32'hB);
      enable_mask = 4'b1111;

      serve(ST, 1, 0, R_OK, 1, '0);
      serve(ST, 2, 0, R_OK, 1, '0);
      serve(CM, 2, 0, R_NONE, 0, '0);
      serve(ST, 3, 10, R_ERR, 1, '0);
      chk("link_after_one_err", 32'(link_up), 32'hF);
      serve(ST, 0, 0, R_OK, 1, '0);
      sp_update_req = 4'b0100;
      tick();
      sp_update_req = '0;
      serve(ST, 1, 0, R_OK, 1, '0);
      serve(ST, 2, 0, R_OK, 1, '0);
      serve(SP, 2, 0, R_NONE, 0, 4'b0100);
      serve(ST, 3, 0, R_OK, 1, '0);
      serve(ST, 0, 0, R_OK, 1, '0);
      serve(ST, 1, 0, R_OK, 1, '0);
      serve(ST, 2, 0, R_OK, 1, '0);
      serve(CM, 2, 0, R_NONE, 0, '0);
      serve(ST, 3, 0, R_OK, 1, '0);

      // Only motor 1, 5000-cycle slots, three silent responses.
      enable_mask         = 4'b0010;
      update_frequency_Hz = 32'd2500;
      serve(ST, 1, 0, R_NONE, 0, '0);
      serve(ST, 1, 0, R_NONE, 0, '0);
      serve(ST, 1, 0, R_NONE, 0, '0);
      repeat (3990) tick();
      chk("link1_before_3rd_timeout", 32'(link_up[1]), 32'd1);
      repeat (20) tick();
      chk("link_after_3rd_timeout", 32'(link_up), 32'hD);
      serve(ST, 1, 0, R_OK, 1, '0);
      serve(CM, 1, 0, R_NONE, 0, '0);
      chk("overrun_none_yet", 32'(overrun_count), 32'd0);

      // 625-cycle slots with a response arriving after the slot ends.
      update_frequency_Hz = 32'd20000;
      serve(ST, 1, 0, R_OK, 700, '0);
      tick();
      tick();
      chk("next_slot_immediate", 32'(cmd_valid), 32'd1);
      chk("overrun_one", 32'(overrun_count), 32'd1);
      serve(ST, 1, 0, R_OK, 2, '0);
      n = 0;
      while (!cmd_valid && n < 2000) begin
         tick();
         n++;
      end
      chk("valid_before_reset", 32'(cmd_valid), 32'd1);
      chk("overrun_still_one", 32'(overrun_count), 32'd1);

      // Reset in the middle of an offered command.
      reset = 1'b1;
      tick();
      chk("midrst_valid", 32'(cmd_valid), 32'd0);
      chk("midrst_motor", 32'(cmd_motor), 32'd3);
      chk("midrst_link", 32'(link_up), 32'd0);
      chk("midrst_overrun", 32'(overrun_count), 32'd0);
      enable_mask = 4'b1011;
      tick();
      reset = 1'b0;
      tick();
      chk("first_slot_valid", 32'(cmd_valid), 32'd1);
      chk("first_slot_motor", 32'(cmd_motor), 32'd0);
      serve(ST, 0, 0, R_OK, 1, '0);
      serve(CM, 0, 0, R_NONE, 0, '0);
      repeat (20) tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/motor_bus_scheduler.md
MOTOR_BUS_SCHEDULER -- requirements
Module: motor_bus_scheduler

Interface
REQ-001 SHALL have parameters: NUMBER_OF_MOTORS, default 8, count of motors on the bus; CLK_FREQ_HZ, default 50_000_000, clock frequency; RESPONSE_TIMEOUT_CYCLES, default 4000, wait for a status response after the request has been sent.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port update_frequency_Hz, input, 32, per-motor poll rate.
REQ-005 SHALL have port enable_mask, input, NUMBER_OF_MOTORS, motors included in polling.
REQ-006 SHALL have port cm_update_req, input, NUMBER_OF_MOTORS, per-motor pulse meaning the control-mode config changed.
REQ-007 SHALL have port sp_update_req, input, NUMBER_OF_MOTORS, per-motor pulse meaning the setpoint or colour changed.
REQ-008 SHALL have port cmd_valid, output, 1, a frame command is offered.
REQ-009 SHALL have port cmd_ready, input, 1, the frame engine accepts the command.
REQ-010 SHALL have port cmd_type, output, 2, frame type: 0 = STATUS_REQUEST, 1 = SETPOINT, 2 = CONTROL_MODE.
REQ-011 SHALL have port cmd_motor, output, 8, motor index for the command.
REQ-012 SHALL have port cmd_done, input, 1, pulse when the last byte of the frame has been transmitted.
REQ-013 SHALL have port rsp_ok, input, 1, pulse when a CRC-valid status frame from cmd_motor is received.
REQ-014 SHALL have port rsp_err, input, 1, pulse when a CRC error or wrong id is received.
REQ-015 SHALL have port link_up, output, NUMBER_OF_MOTORS, per-motor link status.
REQ-016 SHALL have port overrun_count, output, 16, count of slot overruns, saturating.

Function
REQ-017 Slot period SHALL be CLK_FREQ_HZ / max(update_frequency_Hz,1) / NUMBER_OF_MOTORS cycles, recomputed at each slot start; the down-counter reloads at slot start.
REQ-018 FSM states SHALL be IDLE, ISSUE_STATUS, WAIT_TX_STATUS, WAIT_RESP, ISSUE_UPDATE, WAIT_TX_UPDATE.
REQ-019 Slot start SHALL happen in IDLE when the slot counter is 0.
- On slot start, cmd_motor advances round-robin to the next motor set in enable_mask, wrapping from NUMBER_OF_MOTORS-1 to 0.
- The FSM then goes to ISSUE_STATUS.
- If enable_mask is 0, the FSM stays in IDLE and the motor index is unchanged.
REQ-020 cmd_valid SHALL assert the cycle after entry to ISSUE_*.
- cmd_type and cmd_motor stay stable while cmd_valid is high.
- cmd_valid drops the cycle after a cycle where cmd_valid and cmd_ready are both high.
- cmd_valid never deasserts without that handshake.
REQ-021 WAIT_TX_STATUS SHALL wait for cmd_done, then load the response counter with RESPONSE_TIMEOUT_CYCLES and enter WAIT_RESP.
REQ-022 WAIT_RESP SHALL behave as follows:
- rsp_ok: set link_up[motor], clear the fail counter. If pending_cm[motor] is set or link_up[motor] was 0, go to ISSUE_UPDATE with CONTROL_MODE; else if pending_sp[motor] is set, go to ISSUE_UPDATE with SETPOINT; else go to IDLE.
- rsp_err or counter at 0: increment the 2-bit fail counter (saturating) and go to IDLE; the third consecutive failure clears link_up[motor].
- rsp_ok and rsp_err in the same cycle: rsp_ok wins.
REQ-023 CONTROL_MODE acceptance SHALL clear both pending_cm and pending_sp for that motor, because that frame carries the setpoint; SETPOINT acceptance SHALL clear pending_sp only.
REQ-024 A request pulse coinciding with its pending-clear SHALL leave the pending bit set.
REQ-025 If the slot counter reaches 0 while the FSM is not in IDLE, overrun_count SHALL increment by 1, saturating at 16'hFFFF; the next slot then starts in the first IDLE cycle.
REQ-026 rsp_ok, rsp_err and cmd_done outside their waiting state SHALL be ignored.
REQ-027 update_frequency_Hz = 0 SHALL be treated as 1.

Reset
REQ-028 On reset, all outputs SHALL be driven as follows: cmd_valid=0, cmd_type=0, cmd_motor=NUMBER_OF_MOTORS-1, link_up=0, overrun_count=0.
REQ-029 On reset, internal state SHALL be: pending bits 0, fail counters 0, slot counter 0, FSM in IDLE.
REQ-030 After reset the first slot SHALL start on the first cycle after reset deasserts and address motor 0 when it is enabled.
REQ-031 Reset mid-frame SHALL abort immediately with no further handshake.

Structure
REQ-032 Package motor_bus_pkg SHALL hold the cmd_type enum, the FSM state enum and the frame-type constants shared with the frame engine.
REQ-033 The slot counter SHALL be the sub-module motor_bus_slot_timer (inputs: period, start; output: expired).

Verification
REQ-034 NUMBER_OF_MOTORS=4, enable_mask=4'b1011, rsp_ok always -> STATUS_REQUEST commands to motors 0,1,3,0 in order.
REQ-035 First rsp_ok for motor 0 -> CONTROL_MODE command to motor 0 (link was down); second slot for motor 0 with no pending -> STATUS_REQUEST only.
REQ-036 sp_update_req[2] pulse, then rsp_ok for motor 2 with link up -> SETPOINT to motor 2; a cm_update_req[2] pulse on the acceptance cycle -> next motor-2 slot sends CONTROL_MODE.
REQ-037 No response three times for motor 1 -> link_up[1] falls after the third timeout of RESPONSE_TIMEOUT_CYCLES=4000.
REQ-038 cmd_ready held low for 10 cycles -> cmd_valid, cmd_type and cmd_motor stable for 10 cycles.
REQ-039 CLK_FREQ_HZ=50_000_000, update_frequency_Hz=10000, N=8 (625-cycle slot), response delayed past the slot -> overrun_count=1, and the next slot starts immediately on return to IDLE.
